cl_stream_ctl_regs: RTL

- cfg_bus slave hung off the OCL slave's streaming slot (256 B window); consumes the wr/rd pulses it issues, returns a single ack pulse with rdata.
- Holds the streaming control/status registers and a run-control FSM (IDLE/RUN/FLUSH).
- Drives the datapath stream engine.
- Produces the 1-cycle finished pulse that clears the upstream streaming_active flag.

---
 rtl/cl_stream_ctl_regs_pkg.sv | 29 ++
 rtl/cl_stream_ctl_regs_if.sv | 15 +
 rtl/cl_stream_ctl_regs_sat_cnt.sv | 22 ++
 rtl/cl_stream_ctl_regs.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cl_stream_ctl_regs_pkg.sv
// Shared constants for the streaming control block: register offsets, bit
// positions within CTRL/STATUS and the run-control state encoding.
package cl_stream_pkg;

    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_LEN       = 8'h08;
    localparam logic [7:0] REG_TIMEOUT   = 8'h0C;
    localparam logic [7:0] REG_BEAT_CNT  = 8'h10;
    localparam logic [7:0] REG_CYCLE_CNT = 8'h14;
    localparam logic [7:0] REG_SCRATCH   = 8'h18;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_ACTIVE_BIT  = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } stream_state_t;

endpackage

// File: rtl/cl_stream_ctl_regs_if.sv
// Single-cycle wr/rd pulse bus from the OCL slave; the register block sees
// the request side as inputs and returns ack/rdata.
interface cfg_bus_t;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic        ack;
    logic [31:0] rdata;

    modport master (input addr, wdata, wr, rd, output ack, rdata);
    modport slave  (output addr, wdata, wr, rd, input ack, rdata);

endinterface

// File: rtl/cl_stream_ctl_regs_sat_cnt.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module cl_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         sync_rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cl_stream_ctl_regs.sv
// Streaming control/status registers and the IDLE/RUN/FLUSH run-control FSM
// that sequences the datapath stream engine.
module cl_stream_ctl_regs
    import cl_stream_pkg::*;
#(
    parameter int unsigned      CNT_W       = 32,
    parameter logic [CNT_W-1:0] TIMEOUT_RST = '0
) (
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             sh_cl_flr_assert_q,
    cfg_bus_t.master         cfg_bus,
    input  logic             strm_beat,
    input  logic             strm_idle,
    output logic             strm_start,
    output logic             strm_abort,
    output logic             strm_active,
    output logic [CNT_W-1:0] strm_len,
    output logic             strm_finished,
    output logic             irq_req
);

    stream_state_t    state, state_nxt;
    logic [CNT_W-1:0] len_q, tmo_q, beat_cnt, cycle_cnt, beat_plus;
    logic [31:0]      scratch_q, rd_val;
    logic [7:0]       offs;
    logic             addr_unused;
    logic             irq_en_q, done_q, tout_q;
    logic             wr_go, rd_go, wr_ctrl, wr_status;
    logic             start_req, abort_req, timeout_hit;
    logic             start_nxt, abort_nxt, finished_nxt;
    logic             done_set, tout_set, run_clr, cnt_clr;

    assign offs        = cfg_bus.addr[7:0];
    assign addr_unused = ^cfg_bus.addr[31:8];
    assign wr_go       = cfg_bus.wr;
    assign rd_go       = cfg_bus.rd & ~cfg_bus.wr;
    assign wr_ctrl     = wr_go && (offs == REG_CTRL);
    assign wr_status   = wr_go && (offs == REG_STATUS);
    assign start_req   = wr_ctrl && cfg_bus.wdata[CTRL_START_BIT];
    assign abort_req   = wr_ctrl && cfg_bus.wdata[CTRL_ABORT_BIT];

    // Completion compares against the beat count including this cycle's beat.
    assign beat_plus   = (strm_beat && (beat_cnt != '1)) ? beat_cnt + CNT_W'(1) : beat_cnt;
    assign timeout_hit = (tmo_q != '0) && (cycle_cnt == tmo_q - CNT_W'(1));

    assign strm_active = (state != ST_IDLE);
    assign strm_len    = len_q;
    assign irq_req     = irq_en_q & (done_q | tout_q);

    always_comb begin
        state_nxt    = state;
        start_nxt    = 1'b0;
        abort_nxt    = 1'b0;
        finished_nxt = 1'b0;
        done_set     = 1'b0;
        tout_set     = 1'b0;
        run_clr      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_RUN;
                    start_nxt = 1'b1;
                    run_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (beat_plus == len_q) begin
                    state_nxt    = ST_IDLE;
                    finished_nxt = 1'b1;
                    done_set     = 1'b1;
                end else if (abort_req || timeout_hit) begin
                    state_nxt = ST_FLUSH;
                    abort_nxt = 1'b1;
                    tout_set  = timeout_hit;
                end
            end
            ST_FLUSH: begin
                if (strm_idle) begin
                    state_nxt    = ST_IDLE;
                    finished_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // FLR silently parks the FSM: no completion or abort pulses escape.
        if (sh_cl_flr_assert_q) begin
            state_nxt    = ST_IDLE;
            start_nxt    = 1'b0;
            abort_nxt    = 1'b0;
            finished_nxt = 1'b0;
            done_set     = 1'b0;
            tout_set     = 1'b0;
            run_clr      = 1'b0;
        end
    end

    assign cnt_clr = run_clr | sh_cl_flr_assert_q;

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state         <= ST_IDLE;
            strm_start    <= 1'b0;
            strm_abort    <= 1'b0;
            strm_finished <= 1'b0;
        end else begin
            state         <= state_nxt;
            strm_start    <= start_nxt;
            strm_abort    <= abort_nxt;
            strm_finished <= finished_nxt;
        end
    end

    cl_sat_cnt #(.W(CNT_W)) u_beat_cnt (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clr        (cnt_clr),
        .inc        (strm_beat && (state != ST_IDLE)),
        .cnt        (beat_cnt)
    );

    cl_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clr        (cnt_clr),
        .inc        (state != ST_IDLE),
        .cnt        (cycle_cnt)
    );

    // Hardware set beats a same-cycle W1C of the same bit.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            done_q <= 1'b0;
            tout_q <= 1'b0;
        end else if (cnt_clr) begin
            done_q <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            done_q <= done_set | (done_q & ~(wr_status & cfg_bus.wdata[STATUS_DONE_BIT]));
            tout_q <= tout_set | (tout_q & ~(wr_status & cfg_bus.wdata[STATUS_TIMEOUT_BIT]));
        end
    end

    // LEN/TIMEOUT are frozen while the engine is running so strm_len stays stable.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            len_q     <= '0;
            tmo_q     <= TIMEOUT_RST;
            scratch_q <= '0;
            irq_en_q  <= 1'b0;
        end else if (wr_go) begin
            case (offs)
                REG_CTRL:    irq_en_q <= cfg_bus.wdata[CTRL_IRQ_EN_BIT];
                REG_LEN:     if (state == ST_IDLE) len_q <= cfg_bus.wdata[CNT_W-1:0];
                REG_TIMEOUT: if (state == ST_IDLE) tmo_q <= cfg_bus.wdata[CNT_W-1:0];
                REG_SCRATCH: scratch_q <= cfg_bus.wdata;
                default:     ;
            endcase
        end
    end

    always_comb begin
        rd_val = DEADBEEF;
        case (offs)
            REG_CTRL: begin
                rd_val                  = '0;
                rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_STATUS: begin
                rd_val                     = '0;
                rd_val[STATUS_ACTIVE_BIT]  = strm_active;
                rd_val[STATUS_DONE_BIT]    = done_q;
                rd_val[STATUS_TIMEOUT_BIT] = tout_q;
            end
            REG_LEN:       rd_val = 32'(len_q);
            REG_TIMEOUT:   rd_val = 32'(tmo_q);
            REG_BEAT_CNT:  rd_val = 32'(beat_cnt);
            REG_CYCLE_CNT: rd_val = 32'(cycle_cnt);
            REG_SCRATCH:   rd_val = scratch_q;
            default:       ;
        endcase
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            cfg_bus.ack   <= 1'b0;
            cfg_bus.rdata <= '0;
        end else begin
            cfg_bus.ack   <= wr_go | rd_go;
            cfg_bus.rdata <= rd_go ? rd_val : '0;
        end
    end

endmodule
